// File: rtl/rom_read_master_pkg.sv
// Shared definitions for the ROM read master: bus widths, FSM state encoding
// and the default timeout depth.
package rom_read_master_pkg;

  localparam int ROM_ADDR_W          = 11;
  localparam int WORD_DATA_W         = 32;
  localparam int ROM_RD_STATE_W      = 2;
  localparam int DEFAULT_TIMEOUT_CYC = 15;

  typedef enum logic [ROM_RD_STATE_W-1:0] {
    ROM_RD_IDLE = 2'd0,
    ROM_RD_ADDR = 2'd1,
    ROM_RD_WAIT = 2'd2
  } rom_rd_state_e;

endpackage

// File: rtl/rom_read_master_if.sv
// Client request/response and ROM responder signals of the ROM read master.
// The master modport is the initiator's view; slave is the client+ROM side.
interface rom_read_master_if
  import rom_read_master_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = WORD_DATA_W
);
  logic              req;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_word;
  logic              err;
  logic              cs_;
  logic              as_;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rd_data;
  logic              rdy_;

  modport master (
    input  req, req_addr, rd_data, rdy_,
    output req_ready, rd_valid, rd_word, err, cs_, as_, addr
  );

  modport slave (
    output req, req_addr, rd_data, rdy_,
    input  req_ready, rd_valid, rd_word, err, cs_, as_, addr
  );
endinterface

// File: rtl/rom_rd_timeout_cnt.sv
// 8-bit WAIT-state stall counter; tc_o flags the stall cycle that reaches
// TIMEOUT_CYC so the master can abort in that same cycle.
module rom_rd_timeout_cnt
  import rom_read_master_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Terminal only on a stalled cycle, so rdy_=0 in that cycle always wins.
  assign tc_o = inc_i && (cnt_q == 8'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/rom_read_master.sv
// Single-word ROM read initiator (IDLE -> ADDR -> WAIT) over the cs_/as_/rdy_
// protocol. Optional WAIT abort is compiled in with ROM_RD_TIMEOUT_EN.
module rom_read_master
  import rom_read_master_pkg::*;
#(
  parameter int ADDR_W      = ROM_ADDR_W,
  parameter int DATA_W      = WORD_DATA_W,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input logic              clk,
  input logic              reset,
  rom_read_master_if.master bus
);
  rom_rd_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rd_word_q, rd_word_d;
  logic              rd_valid_q, rd_valid_d;
  logic              cs_n, as_n, req_ready;
  logic              tmo_tc;

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("rom_read_master: TIMEOUT_CYC must be in 1..255");
  end

`ifdef ROM_RD_TIMEOUT_EN
  logic err_q;

  rom_rd_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (state_q == ROM_RD_ADDR),
    .inc_i ((state_q == ROM_RD_WAIT) && bus.rdy_),
    .tc_o  (tmo_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= tmo_tc;
  end

  assign bus.err = err_q;
`else
  assign tmo_tc  = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    rd_word_d  = rd_word_q;
    rd_valid_d = 1'b0;
    cs_n       = 1'b1;
    as_n       = 1'b1;
    req_ready  = 1'b0;

    case (state_q)
      ROM_RD_IDLE: begin
        req_ready = 1'b1;
        if (bus.req) begin
          addr_d  = bus.req_addr;
          state_d = ROM_RD_ADDR;
        end
      end
      ROM_RD_ADDR: begin
        cs_n    = 1'b0;
        as_n    = 1'b0;
        state_d = ROM_RD_WAIT;
      end
      ROM_RD_WAIT: begin
        cs_n = 1'b0;
        if (!bus.rdy_) begin
          rd_word_d  = bus.rd_data;
          rd_valid_d = 1'b1;
          req_ready  = 1'b1;
          if (bus.req) begin
            addr_d  = bus.req_addr;
            state_d = ROM_RD_ADDR;
          end else begin
            state_d = ROM_RD_IDLE;
          end
        end else if (tmo_tc) begin
          state_d = ROM_RD_IDLE;
        end
      end
      default: state_d = ROM_RD_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ROM_RD_IDLE;
      addr_q     <= '0;
      rd_word_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rd_word_q  <= rd_word_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.cs_       = cs_n;
  assign bus.as_       = as_n;
  assign bus.addr      = addr_q;
  assign bus.rd_word   = rd_word_q;
  assign bus.rd_valid  = rd_valid_q;
endmodule

// File: tb/tb_rom_read_master.sv
// Directed bench for rom_read_master: single, back-to-back, stalled, timeout
// (ROM_RD_TIMEOUT_EN), mid-transaction reset and ignored-input scenarios.
module tb_rom_read_master;
  import rom_read_master_pkg::*;

  localparam int AW  = 11;
  localparam int DW  = 32;
  localparam int TMO = 15;
  localparam logic [DW-1:0] JUNK = 32'h5A5A_5A5A;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   n_valid = 0;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] last_word;

  rom_read_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  rom_read_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ROM contents seen by the model: one fixed boot word, otherwise address-tagged.
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return (a == 11'h004) ? 32'hDEAD_BEEF : {5'h00, a, 16'hC0DE};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, sample mid-cycle.
  task automatic cyc(input logic rst, input logic rq, input logic [AW-1:0] ra,
                     input logic rdy_n, input logic [DW-1:0] rd);
    @(posedge clk);
    #1;
    reset        = rst;
    bus.req      = rq;
    bus.req_addr = ra;
    bus.rdy_     = rdy_n;
    bus.rd_data  = rd;
    @(negedge clk);
    if (bus.rd_valid === 1'b1) begin
      n_valid++;
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) check("rd_word", 64'(bus.rd_word), 64'(sb.pop_front()));
    end
  endtask

  // ROM answers this WAIT cycle with the word at address a.
  task automatic reply(input logic [AW-1:0] a, input logic rq, input logic [AW-1:0] ra);
    sb.push_back(rom_word(a));
    last_word = rom_word(a);
    cyc(1'b0, rq, ra, 1'b0, rom_word(a));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0;
    reset        = 1'b1;
    bus.req      = 1'b0;
    bus.req_addr = '0;
    bus.rdy_     = 1'b1;
    bus.rd_data  = JUNK;
    last_word    = '0;

    // Reset state
    cyc(1, 0, 0, 1, JUNK);
    cyc(1, 0, 0, 1, JUNK);
    check("rst_cs", bus.cs_, 1);
    check("rst_as", bus.as_, 1);
    check("rst_addr", bus.addr, 0);
    check("rst_rd_word", bus.rd_word, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_err", bus.err, 0);
    check("rst_req_ready", bus.req_ready, 1);

    // Single read of 11'h004
    cyc(0, 1, 11'h004, 1, JUNK);
    check("single_ready_idle", bus.req_ready, 1);
    cyc(0, 0, 0, 1, JUNK);
    check("single_cs_addr", bus.cs_, 0);
    check("single_as_addr", bus.as_, 0);
    check("single_addr", bus.addr, 11'h004);
    check("single_ready_addr", bus.req_ready, 0);
    reply(11'h004, 0, 0);
    check("single_cs_wait", bus.cs_, 0);
    check("single_as_wait", bus.as_, 1);
    check("single_ready_wait", bus.req_ready, 1);
    check("single_valid_early", bus.rd_valid, 0);
    cyc(0, 0, 0, 1, JUNK);
    check("single_valid", bus.rd_valid, 1);
    check("single_word", bus.rd_word, 32'hDEAD_BEEF);
    check("single_idle_cs", bus.cs_, 1);
    cyc(0, 0, 0, 1, JUNK);
    check("single_valid_pulse", bus.rd_valid, 0);

    // Back-to-back over addresses 0,1,2 with req held
    v0 = n_valid;
    cyc(0, 1, 0, 1, JUNK);
    for (int i = 0; i < 3; i++) begin
      cyc(0, i < 2, AW'(i + 1), 1, JUNK);
      check("b2b_as_low", bus.as_, 0);
      check("b2b_addr", bus.addr, i);
      check("b2b_valid_addr", bus.rd_valid, i > 0);
      reply(AW'(i), i < 2, AW'(i + 1));
      check("b2b_as_high", bus.as_, 1);
      check("b2b_valid_wait", bus.rd_valid, 0);
    end
    cyc(0, 0, 0, 1, JUNK);
    check("b2b_valid_last", bus.rd_valid, 1);
    check("b2b_idle_cs", bus.cs_, 1);
    check("b2b_pulses", n_valid - v0, 3);

    // Stalled responder: four stall cycles in WAIT
    cyc(0, 1, 11'h007, 1, JUNK);
    cyc(0, 0, 0, 1, JUNK);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, JUNK);
      check("stall_cs", bus.cs_, 0);
      check("stall_as", bus.as_, 1);
      check("stall_addr", bus.addr, 11'h007);
      check("stall_ready", bus.req_ready, 0);
      check("stall_valid", bus.rd_valid, 0);
    end
    reply(11'h007, 0, 0);
    cyc(0, 0, 0, 1, JUNK);
    check("stall_valid_n7", bus.rd_valid, 1);

`ifdef ROM_RD_TIMEOUT_EN
    // Timeout: rdy_ never arrives
    cyc(0, 1, 11'h009, 1, JUNK);
    cyc(0, 0, 0, 1, JUNK);
    for (int i = 0; i < TMO; i++) begin
      cyc(0, 0, 0, 1, JUNK);
      check("tmo_err_early", bus.err, 0);
      check("tmo_cs_wait", bus.cs_, 0);
    end
    cyc(0, 0, 0, 1, JUNK);
    check("tmo_err", bus.err, 1);
    check("tmo_valid", bus.rd_valid, 0);
    check("tmo_cs", bus.cs_, 1);
    check("tmo_idle", bus.req_ready, 1);
    check("tmo_word_kept", bus.rd_word, last_word);
    cyc(0, 1, 11'h004, 1, JUNK);
    check("tmo_err_pulse", bus.err, 0);
    cyc(0, 0, 0, 1, JUNK);
    reply(11'h004, 0, 0);
    cyc(0, 0, 0, 1, JUNK);
    check("tmo_next_valid", bus.rd_valid, 1);
`else
    // Without the timeout, a long stall neither aborts nor raises err
    cyc(0, 1, 11'h009, 1, JUNK);
    cyc(0, 0, 0, 1, JUNK);
    for (int i = 0; i < TMO + 5; i++) begin
      cyc(0, 0, 0, 1, JUNK);
      check("nt_err", bus.err, 0);
      check("nt_cs", bus.cs_, 0);
    end
    reply(11'h009, 0, 0);
    cyc(0, 0, 0, 1, JUNK);
    check("nt_valid", bus.rd_valid, 1);
`endif

    // Reset during WAIT, with rdy_=0 arriving in the same and next cycles
    v0 = n_valid;
    cyc(0, 1, 11'h005, 1, JUNK);
    cyc(0, 0, 0, 1, JUNK);
    cyc(0, 0, 0, 1, JUNK);
    cyc(1, 0, 0, 0, rom_word(11'h005));
    cyc(0, 0, 0, 0, rom_word(11'h005));
    check("rstmid_cs", bus.cs_, 1);
    check("rstmid_as", bus.as_, 1);
    check("rstmid_addr", bus.addr, 0);
    check("rstmid_word", bus.rd_word, 0);
    cyc(0, 0, 0, 1, JUNK);
    check("rstmid_no_valid", n_valid - v0, 0);
    last_word = '0;

    // Spurious rdy_=0 while IDLE
    cyc(0, 0, 0, 0, 32'hFFFF_FFFF);
    cyc(0, 0, 0, 0, 32'hFFFF_FFFF);
    check("spur_valid", bus.rd_valid, 0);
    check("spur_word", bus.rd_word, last_word);
    check("spur_err", bus.err, 0);
    check("spur_cs", bus.cs_, 1);

    // req pulsed with another address during ADDR is ignored
    cyc(0, 1, 11'h003, 1, JUNK);
    cyc(0, 1, 11'h7FF, 1, JUNK);
    check("ign_as", bus.as_, 0);
    reply(11'h003, 0, 0);
    check("ign_addr", bus.addr, 11'h003);
    check("ign_err", bus.err, 0);
    cyc(0, 0, 0, 1, JUNK);
    check("ign_valid", bus.rd_valid, 1);
    cyc(0, 0, 0, 1, JUNK);
    check("ign_idle_cs", bus.cs_, 1);
    check("ign_idle_as", bus.as_, 1);

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
